// File: rtl/fp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fp_ctrl_pkg
// Shared definitions for the floating-point add sequencer:
//   fp_seq_state_t : sequencer FSM state encoding
//   FP_OP_ADD/SUB  : request opcode encodings
//   fp_dp_ctrl_t   : bundle of the addition stage control lines
// ----------------------------------------------------------------------------
package fp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_N = 3'd2,
        LOAD_A = 3'd3,
        RUN    = 3'd4,
        RESP   = 3'd5
    } fp_seq_state_t;

    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

    typedef struct packed {
        logic rst;
        logic en;
        logic loadN;
        logic loadA;
        logic plusminus;
        logic cin;
    } fp_dp_ctrl_t;

endpackage

// File: rtl/fp_add_sequencer_if.sv
// ----------------------------------------------------------------------------
// fp_add_sequencer_if
// Request/response bus of the floating-point add sequencer.
//   req_*  : requester -> sequencer (req_ready flows back)
//   resp_* : sequencer -> consumer  (resp_ready flows back)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised its payload is held
// constant and valid stays high until that transfer edge.
// Modports: master = requester/consumer side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface fp_add_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_sum;
    logic        resp_cout;
    logic        resp_timeout;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_cout, resp_timeout
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_cout, resp_timeout
    );
endinterface

// File: rtl/fp_seq_timeout.sv
// ----------------------------------------------------------------------------
// fp_seq_timeout
// RUN-phase cycle counter of the add sequencer.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : force the count to zero
//   inc_i      : advance the count by one
//   expired_o  : count has reached TIMEOUT_CYCLES-1 (last allowed RUN cycle)
// ----------------------------------------------------------------------------
module fp_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fp_add_sequencer.sv
// ----------------------------------------------------------------------------
// fp_add_sequencer
// Sequences one add/subtract through the 32-bit FP addition stage:
// CLEAR -> LOAD_N -> LOAD_A -> RUN (wait for dp_ready, bounded) -> RESP.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request and held response handshakes
//   dp_rst .. dp_cin  : stage controls (Moore decodes of the state)
//   dp_a, dp_b        : latched operands
//   dp_sum/cout/ready : stage results
//   dbg_state_o       : current FSM state
// ----------------------------------------------------------------------------
module fp_add_sequencer
    import fp_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_sequencer_if.slave   bus,
    output logic                dp_rst,
    output logic                dp_en,
    output logic                dp_loadN,
    output logic                dp_loadA,
    output logic                dp_plusminus,
    output logic                dp_cin,
    output logic [31:0]         dp_a,
    output logic [31:0]         dp_b,
    input  logic [31:0]         dp_sum,
    input  logic                dp_cout,
    input  logic                dp_ready,
    output fp_seq_state_t       dbg_state_o
);

    fp_seq_state_t state_q, state_d;
    logic          op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          tmo_q, tmo_d;
    fp_dp_ctrl_t   ctrl;
    logic          cnt_clear, cnt_inc, expired;

    fp_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        sum_d          = sum_q;
        cout_d         = cout_q;
        tmo_d          = tmo_q;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        ctrl           = '0;
        ctrl.plusminus = op_q;
        ctrl.cin       = op_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                ctrl.rst = 1'b1;
                state_d  = LOAD_N;
            end
            LOAD_N: begin
                ctrl.en    = 1'b1;
                ctrl.loadN = 1'b1;
                state_d    = LOAD_A;
            end
            LOAD_A: begin
                ctrl.en    = 1'b1;
                ctrl.loadA = 1'b1;
                cnt_clear  = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                ctrl.en = 1'b1;
                cnt_inc = 1'b1;
                // Ready is checked first so a result on the last allowed
                // cycle still counts as a valid completion.
                if (dp_ready) begin
                    sum_d   = dp_sum;
                    cout_d  = dp_cout;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (expired) begin
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_ready is masked by rst so nothing is accepted while reset is held
    // even if the state register already reads IDLE.
    assign bus.req_ready    = (state_q == IDLE) && !rst;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_sum     = sum_q;
    assign bus.resp_cout    = cout_q;
    assign bus.resp_timeout = tmo_q;

    assign dp_rst       = ctrl.rst | rst;
    assign dp_en        = ctrl.en;
    assign dp_loadN     = ctrl.loadN;
    assign dp_loadA     = ctrl.loadA;
    assign dp_plusminus = ctrl.plusminus;
    assign dp_cin       = ctrl.cin;
    assign dp_a         = a_q;
    assign dp_b         = b_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fp_add_sequencer
// Self-checking bench for fp_add_sequencer with TIMEOUT_CYCLES=8 and a
// reactive model of the addition stage.
// ----------------------------------------------------------------------------
module tb_fp_add_sequencer;
    import fp_ctrl_pkg::*;

    localparam int TC = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    fp_add_sequencer_if bus();
    logic          dp_rst, dp_en, dp_loadN, dp_loadA, dp_plusminus, dp_cin;
    logic [31:0]   dp_a, dp_b, dp_sum;
    logic          dp_cout, dp_ready;
    fp_seq_state_t dbg_state;

    fp_add_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dp_rst       (dp_rst),
        .dp_en        (dp_en),
        .dp_loadN     (dp_loadN),
        .dp_loadA     (dp_loadA),
        .dp_plusminus (dp_plusminus),
        .dp_cin       (dp_cin),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_sum       (dp_sum),
        .dp_cout      (dp_cout),
        .dp_ready     (dp_ready),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- stage model ----------------
    // Counts RUN cycles from the LOAD_A strobe; raises ready on RUN cycle
    // ready_at (never if -1). force_ready models a stale ready held over.
    // Outside RUN the result lines carry garbage.
    int          ready_at    = -1;
    logic        force_ready = 1'b0;
    logic [31:0] model_sum   = '0;
    logic        model_cout  = 1'b0;
    int          run_idx     = 0;
    logic        in_run;

    assign in_run = dp_en & ~dp_loadN & ~dp_loadA;
    always @(posedge clk) begin
        if (dp_loadA)    run_idx <= 0;
        else if (in_run) run_idx <= run_idx + 1;
    end
    assign dp_ready = force_ready | (in_run & (run_idx == ready_at));
    assign dp_sum   = in_run ? model_sum : 32'hDEAD_BEEF;
    assign dp_cout  = in_run ? model_cout : 1'b1;

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];   // {timeout, cout, sum}
    logic [33:0] exp_v;
    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- driver tasks ----------------
    // Returns t = the cycle in which the request is accepted; leaves the
    // caller at the negedge of cycle t+1.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                             input logic op, output int t);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_wait: req_ready=%b required 1", bus.req_ready);
        end
        t = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for resp_valid; lat = cycles from accept, -1 on expiry.
    task automatic wait_resp(input int t0, output int lat);
        int n;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = bus.resp_valid ? (cyc - t0) : -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_timeout,
             dp_en, dp_loadN, dp_loadA, dp_plusminus, dp_cin, dp_a, dp_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h en=%b a=%h b=%h required all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_sum, dp_en, dp_a, dp_b);
        end
        n_cmp++;
        if (dp_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_dp_rst: got %b required 1", dp_rst);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_bad++;
            $display("FAIL reset_release: req_ready=%b state=%0d required 1/IDLE",
                     bus.req_ready, dbg_state);
        end
    endtask

    task automatic test_add();
        int t, lat;
        ready_at = 0; model_sum = 32'h4000_0000; model_cout = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h4000_0000});
        drive_req(32'h3F80_0000, 32'h3F80_0000, FP_OP_ADD, t);
        wait_resp(t, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL add_latency: got %0d required 5", lat);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL add_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
    endtask

    task automatic test_sub();
        int t, lat, n, bad;
        ready_at = 2; model_sum = 32'h4000_0000; model_cout = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'h4000_0000});
        drive_req(32'h4040_0000, 32'h3F80_0000, FP_OP_SUB, t);
        n = 0; bad = 0;
        while (!bus.resp_valid && n < 200) begin
            if (!(dp_plusminus === 1'b1 && dp_cin === 1'b1 &&
                  dp_a === 32'h4040_0000 && dp_b === 32'h3F80_0000)) bad++;
            @(negedge clk);
            n++;
        end
        lat = bus.resp_valid ? (cyc - t) : -1;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL sub_ctrl_stable: %0d bad cycles required 0", bad);
        end
        n_cmp++;
        if (lat !== 7) begin
            n_bad++;
            $display("FAIL sub_latency: got %0d required 7", lat);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL sub_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
    endtask

    task automatic test_timeout();
        int t, lat;
        ready_at = -1; model_sum = 32'h1234_5678; model_cout = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        drive_req(32'h4120_0000, 32'hC120_0000, FP_OP_ADD, t);
        wait_resp(t, lat);
        n_cmp++;
        if (lat !== 4 + TC) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d required %0d", lat, 4 + TC);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL timeout_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_backpressure_stale();
        int t, lat, bad;
        logic [33:0] snap;
        bus.resp_ready = 1'b0;
        force_ready = 1'b1; ready_at = -1;
        model_sum = 32'h3FC0_0000; model_cout = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'h3FC0_0000});
        drive_req(32'h3F00_0000, 32'h3F80_0000, FP_OP_ADD, t);
        wait_resp(t, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL stale_latency: got %0d required 5", lat);
        end
        force_ready = 1'b0;
        snap = {bus.resp_timeout, bus.resp_cout, bus.resp_sum};
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                {bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== snap) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: %0d bad cycles required 0", bad);
        end
        bus.resp_ready = 1'b1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL stale_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: req_ready=%b resp_valid=%b required 1/0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int t, lat;
        ready_at = -1;
        drive_req(32'h1111_1111, 32'h2222_2222, FP_OP_SUB, t);
        repeat (5) @(negedge clk);   // now in cycle t+6, the 3rd RUN cycle
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== IDLE || dp_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_state: state=%0d dp_rst=%b required IDLE/1", dbg_state, dp_rst);
        end
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_timeout,
             dp_en, dp_loadN, dp_loadA, dp_plusminus, dp_cin, dp_a, dp_b} !== '0) begin
            n_bad++;
            $display("FAIL midrun_outputs: rdy=%b vld=%b en=%b pm=%b a=%h b=%h required all 0",
                     bus.req_ready, bus.resp_valid, dp_en, dp_plusminus, dp_a, dp_b);
        end
        @(negedge clk);
        rst = 1'b0;
        ready_at = 1; model_sum = $urandom; model_cout = 1'b0;
        exp_q.push_back({1'b0, 1'b0, model_sum});
        drive_req(32'h3F80_0000, 32'h4000_0000, FP_OP_ADD, t);
        wait_resp(t, lat);
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL after_reset_latency: got %0d required 6", lat);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL after_reset_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
    endtask

    task automatic test_ready_at_expiry();
        int t, lat;
        ready_at = TC - 1; model_sum = 32'hC000_0000; model_cout = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'hC000_0000});
        drive_req(32'hBF80_0000, 32'h3F80_0000, FP_OP_SUB, t);
        wait_resp(t, lat);
        n_cmp++;
        if (lat !== 4 + TC) begin
            n_bad++;
            $display("FAIL expiry_latency: got %0d required %0d", lat, 4 + TC);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
            n_bad++;
            $display("FAIL expiry_result: got %h required %h",
                     {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int t, lat;
        logic op;
        for (int i = 0; i < 4; i++) begin
            ready_at   = $urandom_range(0, 3);
            model_sum  = $urandom;
            model_cout = 1'($urandom_range(0, 1));
            op         = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, model_cout, model_sum});
            drive_req($urandom, $urandom, op, t);
            wait_resp(t, lat);
            n_cmp++;
            if (lat !== 5 + ready_at || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_latency[%0d]: got %0d req_ready=%b required %0d/0",
                         i, lat, bus.req_ready, 5 + ready_at);
            end
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({bus.resp_timeout, bus.resp_cout, bus.resp_sum} !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_result[%0d]: got %h required %h", i,
                         {bus.resp_timeout, bus.resp_cout, bus.resp_sum}, exp_v);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_timeout();
        test_backpressure_stale();
        test_reset_mid_run();
        test_ready_at_expiry();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
